calu_ctrl: RTL

CALU_CTRL -- requirements
Module: calu_ctrl

---
 rtl/calu_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/calu_ctrl.sv
// calu_ctrl: request/response sequencer that holds operands for an external combinational complex ALU
module calu_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter int SLOW_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_z1,
  input  logic [31:0] req_z2,
  input  logic [3:0]  req_opcode,
  output logic [31:0] calu_z1,
  output logic [31:0] calu_z2,
  output logic [3:0]  calu_opcode,
  input  logic [31:0] calu_zout,
  input  logic [11:0] calu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zout,
  output logic [11:0] rsp_flags,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int MAXN = EXEC_CYCLES > SLOW_CYCLES ? EXEC_CYCLES : SLOW_CYCLES;
  localparam int CW = MAXN > 1 ? $clog2(MAXN) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic accept, slow, done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // a response handshake that coincides with a new request goes straight back to EXEC
  always_comb
    state_d = accept ? EXEC :
              state == EXEC ? (done ? RESP : EXEC) :
              (state == RESP && !rsp_ready) ? RESP : IDLE;
  always_comb begin
    req_ready = state == IDLE || (state == RESP && rsp_ready);
    rsp_valid = state == RESP;
    busy = state != IDLE;
    accept = req_valid && req_ready;
    slow = req_opcode == 4'b0011 || req_opcode == 4'b0100;
    done = state == EXEC && cnt == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      calu_z1 <= '0;
      calu_z2 <= '0;
      calu_opcode <= '0;
      rsp_zout <= '0;
      rsp_flags <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        calu_z1 <= req_z1;
        calu_z2 <= req_z2;
        calu_opcode <= req_opcode;
        cnt <= slow ? CW'(SLOW_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
      end else if (state == EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (done) begin
        rsp_zout <= calu_zout;
        rsp_flags <= calu_flags;
      end
      if (state == RESP && rsp_ready) op_count <= op_count + 1'b1;
    end
endmodule
